expansion_shiftreg_target: RTL and testbench
============================================

// Module: expansion_shiftreg_target
// PURPOSE
//  FPGA-side target (the far end) of the expansion shift-register link; emulates a 74HC595+74HC165 chain.
//  Oversamples the master's SHIFT_CLK/SHIFT_LOAD/serial-data lines in the clk domain.
//  Deserialises output bits to data_out and serialises local inputs (data_in) back to the master.
//  Used on satellite boards so a second FPGA can stand in for discrete shift registers.
// PARAMETERS
//  WIDTH        8        bits per frame (matches master's width)
//  SYNC_STAGES  2        synchroniser flops per input line (>=2)
//  TIMEOUT      1350000  clk cycles without a valid frame before link loss (watchdog build only)
//  SAFE_VALUE   0        data_out value after reset and on link loss
// PORTS
//  clk          in   1      system clock
//  rst          in   1      synchronous reset, active-high
//  shift_clk    in   1      serial clock from master (async)
//  shift_load   in   1      frame latch/load strobe from master (async)
//  shift_sdi    in   1      serial data from master (async)
//  shift_sdo    out  1      serial data to master
//  data_in      in   WIDTH  local inputs, sent to master
//  data_out     out  WIDTH  outputs commanded by master
//  frame_valid  out  1      1-cycle pulse: data_out updated
//  frame_err    out  1      1-cycle pulse: load seen with bit count != WIDTH
//  link_ok      out  1      high after first valid frame (watchdog build: cleared on timeout)
// BEHAVIOUR
//  - Reset values: data_out=SAFE_VALUE, shift_sdo=0, frame_valid=0, frame_err=0, link_ok=0; rx_sr, tx_sr, bit_cnt, sync flops = 0.
//  - All three inputs pass through SYNC_STAGES flops; edges are detected on the last stage vs. one extra flop.
//  - Edge-to-action latency: SYNC_STAGES+1 clk. Master half-period must be >= SYNC_STAGES+3 clk.
//  - shift_clk rising edge: rx_sr <= {rx_sr[WIDTH-2:0], sdi_sync}; tx_sr <= {tx_sr[WIDTH-2:0], 1'b0};
//    bit_cnt += 1, saturating at WIDTH+1; width is $clog2(WIDTH+2).
//  - shift_sdo = tx_sr[WIDTH-1], registered. The MSB is presented first; the master samples before its rising edge.
//  - shift_load rising edge:
//    - bit_cnt==WIDTH: data_out <= rx_sr; frame_valid pulse; link_ok <= 1.
//    - otherwise: data_out is held; frame_err pulse.
//    - Always: tx_sr <= data_in (sampled this cycle); bit_cnt <= 0.
//  - A load edge and a clk edge in the same cycle: the load is processed and the clk edge is discarded (not counted).
//  - Extra clocks beyond WIDTH keep shifting (tail bits shift in, sdo shifts 0s); the frame is flagged at load.
//  - A load with zero clocks reloads tx_sr and flags frame_err (bit_cnt 0 != WIDTH).
//  - FSM LINK: IDLE (after reset) -> UP on first valid frame. UP -> IDLE only on watchdog timeout; link_ok = (state==UP).
//  - rst mid-frame: returns to reset values immediately. A partial frame in progress is lost.
// CONFIGURATION
//  - EXPANSION_TARGET_WATCHDOG_EN defined:
//    - A counter of $clog2(TIMEOUT+1) bits clears on each frame_valid and increments otherwise, saturating.
//    - On reaching TIMEOUT in UP: data_out <= SAFE_VALUE and the state goes to IDLE (link_ok=0) in the same cycle.
//    - The next valid frame restores UP.
//  - Not defined: no counter. UP is permanent until rst, and data_out holds the last frame indefinitely.
// STRUCTURE
//  - Shared package expansion_pkg: link state enum (LINK_IDLE, LINK_UP), default WIDTH/SAFE_VALUE constants.
//  - One sub-module: expansion_sync_edge (SYNC_STAGES synchroniser plus rise detect). Instantiated three times;
//    its level output is used for sdi.
// TESTING
//  1. After rst: data_out=0x00, link_ok=0, shift_sdo=0, no pulses for 100 idle cycles.
//  2. data_in=0xA5, then load, 8 clocks shifting 0x3C MSB-first, then load (half-period 8 clk) ->
//     data_out=0x3C, frame_valid 1 cycle, link_ok=1; sdo bits captured = 1,0,1,0,0,1,0,1.
//  3. 7 clocks then load -> frame_err pulse, data_out unchanged (0x3C). 9 clocks then load -> frame_err.
//  4. Load and clk edges arranged to sync in the same cycle -> no shift occurs, bit_cnt=0, tx_sr=data_in.
//  5. WATCHDOG_EN, TIMEOUT=1000: valid frame 0xFF, then idle 1000 clk -> data_out=SAFE_VALUE, link_ok=0;
//     next valid frame 0x81 -> data_out=0x81, link_ok=1.
//  6. rst asserted after 4 of 8 bits -> all reset values; a following full frame 0x5A latches correctly.

Source files
------------

// File: rtl/expansion_pkg.sv
// Shared definitions for the expansion shift-register link: link state encoding and default frame constants.
package expansion_pkg;

  localparam int DEFAULT_WIDTH      = 8;
  localparam int DEFAULT_SAFE_VALUE = 0;

  typedef enum logic [0:0] {
    LINK_IDLE = 1'b0,
    LINK_UP   = 1'b1
  } link_state_e;

endpackage

// File: rtl/expansion_sync_edge.sv
// Multi-flop synchroniser for one asynchronous line, with a rising-edge detect on the synchronised level.
module expansion_sync_edge
  import expansion_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic level_o,
  output logic rise_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level_o = sync_q[STAGES-1];
  assign rise_o  = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/expansion_shiftreg_target.sv
// Far-end target of the expansion shift-register link, emulating a 74HC595+74HC165 chain.
// Define EXPANSION_TARGET_WATCHDOG_EN to drop the link and force SAFE_VALUE after TIMEOUT idle cycles.
module expansion_shiftreg_target
  import expansion_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int SYNC_STAGES = 2,
`ifdef EXPANSION_TARGET_WATCHDOG_EN
  parameter int TIMEOUT     = 1350000,
`endif
  parameter logic [WIDTH-1:0] SAFE_VALUE = WIDTH'(DEFAULT_SAFE_VALUE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_clk,
  input  logic             shift_load,
  input  logic             shift_sdi,
  output logic             shift_sdo,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             frame_valid,
  output logic             frame_err,
  output logic             link_ok
);

  localparam int CNT_W = $clog2(WIDTH + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(WIDTH + 1);

  logic clk_lvl_s, clk_rise_s;
  logic load_lvl_s, load_rise_s;
  logic sdi_lvl_s, sdi_rise_s;
  logic unused_s;
  logic frame_ok_s;

  logic [WIDTH-1:0] rx_sr_q, rx_sr_d;
  logic [WIDTH-1:0] tx_sr_q, tx_sr_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             sdo_q, sdo_d;
  logic             fv_q, fv_d;
  logic             fe_q, fe_d;
  link_state_e      state_q, state_d;

  expansion_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_clk (
    .clk(clk), .rst(rst), .d_i(shift_clk), .level_o(clk_lvl_s), .rise_o(clk_rise_s)
  );
  expansion_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_load (
    .clk(clk), .rst(rst), .d_i(shift_load), .level_o(load_lvl_s), .rise_o(load_rise_s)
  );
  expansion_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sdi (
    .clk(clk), .rst(rst), .d_i(shift_sdi), .level_o(sdi_lvl_s), .rise_o(sdi_rise_s)
  );

  assign unused_s   = &{clk_lvl_s, load_lvl_s, sdi_rise_s};
  assign frame_ok_s = load_rise_s && (bit_cnt_q == CNT_FULL);

`ifdef EXPANSION_TARGET_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            wd_expired_s;

  always_comb begin
    wd_cnt_d = wd_cnt_q;
    if (frame_ok_s) begin
      wd_cnt_d = '0;
    end else if (wd_cnt_q != WD_MAX) begin
      wd_cnt_d = wd_cnt_q + WD_W'(1);
    end else begin
      wd_cnt_d = wd_cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt_q <= '0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
    end
  end

  assign wd_expired_s = !frame_ok_s && (state_q == LINK_UP) && (wd_cnt_q == WD_MAX);
`endif

  // Load has priority: a shift edge landing in the same cycle as a load is dropped.
  always_comb begin
    rx_sr_d    = rx_sr_q;
    tx_sr_d    = tx_sr_q;
    bit_cnt_d  = bit_cnt_q;
    data_out_d = data_out_q;
    state_d    = state_q;
    fv_d       = 1'b0;
    fe_d       = 1'b0;
    if (load_rise_s) begin
      tx_sr_d   = data_in;
      bit_cnt_d = '0;
      if (frame_ok_s) begin
        data_out_d = rx_sr_q;
        fv_d       = 1'b1;
        state_d    = LINK_UP;
      end else begin
        fe_d = 1'b1;
      end
    end else if (clk_rise_s) begin
      rx_sr_d = {rx_sr_q[WIDTH-2:0], sdi_lvl_s};
      tx_sr_d = {tx_sr_q[WIDTH-2:0], 1'b0};
      if (bit_cnt_q != CNT_SAT) begin
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
      end else begin
        bit_cnt_d = bit_cnt_q;
      end
    end else begin
      bit_cnt_d = bit_cnt_q;
    end
`ifdef EXPANSION_TARGET_WATCHDOG_EN
    if (wd_expired_s) begin
      data_out_d = SAFE_VALUE;
      state_d    = LINK_IDLE;
    end else begin
      state_d = state_d;
    end
`endif
    sdo_d = tx_sr_d[WIDTH-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_sr_q    <= '0;
      tx_sr_q    <= '0;
      bit_cnt_q  <= '0;
      data_out_q <= SAFE_VALUE;
      sdo_q      <= 1'b0;
      fv_q       <= 1'b0;
      fe_q       <= 1'b0;
      state_q    <= LINK_IDLE;
    end else begin
      rx_sr_q    <= rx_sr_d;
      tx_sr_q    <= tx_sr_d;
      bit_cnt_q  <= bit_cnt_d;
      data_out_q <= data_out_d;
      sdo_q      <= sdo_d;
      fv_q       <= fv_d;
      fe_q       <= fe_d;
      state_q    <= state_d;
    end
  end

  assign data_out    = data_out_q;
  assign shift_sdo   = sdo_q;
  assign frame_valid = fv_q;
  assign frame_err   = fe_q;
  assign link_ok     = (state_q == LINK_UP);

endmodule

// File: tb/tb_expansion_shiftreg_target.sv
// Directed bench for expansion_shiftreg_target (WIDTH=8, SYNC_STAGES=2, master half-period 8 clk).
module tb_expansion_shiftreg_target;

  localparam int HP = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       shift_clk, shift_load, shift_sdi;
  logic       shift_sdo;
  logic [7:0] data_in, data_out;
  logic       frame_valid, frame_err, link_ok;

  int n_vec = 0;
  int n_err = 0;
  int fv_cnt = 0;
  int fe_cnt = 0;

  expansion_shiftreg_target #(
    .WIDTH(8),
    .SYNC_STAGES(2),
`ifdef EXPANSION_TARGET_WATCHDOG_EN
    .TIMEOUT(1000),
`endif
    .SAFE_VALUE(8'h00)
  ) dut (
    .clk(clk), .rst(rst),
    .shift_clk(shift_clk), .shift_load(shift_load), .shift_sdi(shift_sdi),
    .shift_sdo(shift_sdo), .data_in(data_in), .data_out(data_out),
    .frame_valid(frame_valid), .frame_err(frame_err), .link_ok(link_ok)
  );

  always #5 clk = ~clk;

  // Pulse counters, sampled away from the active edge.
  always @(negedge clk) begin
    if (frame_valid) fv_cnt <= fv_cnt + 1;
    if (frame_err)   fe_cnt <= fe_cnt + 1;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_load();
    shift_load = 1'b1;
    wait_clk(HP);
    shift_load = 1'b0;
    wait_clk(HP);
  endtask

  // Master shifts n bits MSB-first, sampling sdo just before each rising edge.
  task automatic send_bits(input logic [15:0] data, input int n, output logic [15:0] cap);
    cap = 16'h0000;
    for (int i = 0; i < n; i++) begin
      shift_sdi = data[n-1-i];
      wait_clk(HP);
      cap = {cap[14:0], shift_sdo};
      shift_clk = 1'b1;
      wait_clk(HP);
      shift_clk = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wait_clk(4);
    rst = 1'b0;
    wait_clk(1);
    n_vec++; if (data_out !== 8'h00) begin n_err++; $display("FAIL reset_data_out: got %h want 00", data_out); end
    n_vec++; if (link_ok !== 1'b0) begin n_err++; $display("FAIL reset_link_ok: got %b want 0", link_ok); end
    n_vec++; if (shift_sdo !== 1'b0) begin n_err++; $display("FAIL reset_sdo: got %b want 0", shift_sdo); end
    wait_clk(100);
    n_vec++; if (fv_cnt !== 0) begin n_err++; $display("FAIL idle_frame_valid: got %0d want 0", fv_cnt); end
    n_vec++; if (fe_cnt !== 0) begin n_err++; $display("FAIL idle_frame_err: got %0d want 0", fe_cnt); end
  endtask

  task automatic test_frame();
    logic [15:0] cap;
    int fv0, fe0;
    data_in = 8'hA5;
    fe0 = fe_cnt;
    pulse_load();
    n_vec++; if (fe_cnt !== fe0 + 1) begin n_err++; $display("FAIL zero_clk_load_err: got %0d want %0d", fe_cnt, fe0 + 1); end
    n_vec++; if (shift_sdo !== 1'b1) begin n_err++; $display("FAIL sdo_after_load: got %b want 1", shift_sdo); end
    data_in = 8'h00;
    send_bits(16'h003C, 8, cap);
    n_vec++; if (cap[7:0] !== 8'hA5) begin n_err++; $display("FAIL sdo_stream: got %h want a5", cap[7:0]); end
    fv0 = fv_cnt;
    fe0 = fe_cnt;
    pulse_load();
    n_vec++; if (data_out !== 8'h3C) begin n_err++; $display("FAIL frame_data_out: got %h want 3c", data_out); end
    n_vec++; if (fv_cnt !== fv0 + 1) begin n_err++; $display("FAIL frame_valid_pulse: got %0d want %0d", fv_cnt, fv0 + 1); end
    n_vec++; if (fe_cnt !== fe0) begin n_err++; $display("FAIL frame_no_err: got %0d want %0d", fe_cnt, fe0); end
    n_vec++; if (link_ok !== 1'b1) begin n_err++; $display("FAIL frame_link_ok: got %b want 1", link_ok); end
  endtask

  task automatic test_bad_count();
    logic [15:0] cap;
    int fv0, fe0;
    data_in = 8'hFF;
    pulse_load();
    send_bits(16'h007F, 7, cap);
    fv0 = fv_cnt;
    fe0 = fe_cnt;
    pulse_load();
    n_vec++; if (fe_cnt !== fe0 + 1) begin n_err++; $display("FAIL short_frame_err: got %0d want %0d", fe_cnt, fe0 + 1); end
    n_vec++; if (fv_cnt !== fv0) begin n_err++; $display("FAIL short_frame_no_valid: got %0d want %0d", fv_cnt, fv0); end
    n_vec++; if (data_out !== 8'h3C) begin n_err++; $display("FAIL short_frame_hold: got %h want 3c", data_out); end
    send_bits(16'h01FF, 9, cap);
    n_vec++; if (shift_sdo !== 1'b0) begin n_err++; $display("FAIL long_frame_sdo_zero: got %b want 0", shift_sdo); end
    n_vec++; if (cap[8:0] !== 9'h1FE) begin n_err++; $display("FAIL long_frame_sdo_stream: got %h want 1fe", cap[8:0]); end
    fe0 = fe_cnt;
    pulse_load();
    n_vec++; if (fe_cnt !== fe0 + 1) begin n_err++; $display("FAIL long_frame_err: got %0d want %0d", fe_cnt, fe0 + 1); end
    n_vec++; if (data_out !== 8'h3C) begin n_err++; $display("FAIL long_frame_hold: got %h want 3c", data_out); end
    n_vec++; if (link_ok !== 1'b1) begin n_err++; $display("FAIL bad_frames_link_ok: got %b want 1", link_ok); end
  endtask

  task automatic test_same_cycle();
    logic [15:0] cap;
    int fv0, fe0;
    data_in = 8'hC3;
    fe0 = fe_cnt;
    shift_sdi  = 1'b1;
    shift_clk  = 1'b1;
    shift_load = 1'b1;
    wait_clk(HP);
    shift_clk  = 1'b0;
    shift_load = 1'b0;
    wait_clk(HP);
    n_vec++; if (shift_sdo !== 1'b1) begin n_err++; $display("FAIL same_cycle_sdo: got %b want 1", shift_sdo); end
    n_vec++; if (fe_cnt !== fe0 + 1) begin n_err++; $display("FAIL same_cycle_err: got %0d want %0d", fe_cnt, fe0 + 1); end
    send_bits(16'h0096, 8, cap);
    n_vec++; if (cap[7:0] !== 8'hC3) begin n_err++; $display("FAIL same_cycle_tx_intact: got %h want c3", cap[7:0]); end
    fv0 = fv_cnt;
    pulse_load();
    n_vec++; if (fv_cnt !== fv0 + 1) begin n_err++; $display("FAIL same_cycle_cnt_zero: got %0d want %0d", fv_cnt, fv0 + 1); end
    n_vec++; if (data_out !== 8'h96) begin n_err++; $display("FAIL same_cycle_next_frame: got %h want 96", data_out); end
  endtask

  task automatic test_link_hold();
    logic [15:0] cap;
    data_in = 8'h00;
    send_bits(16'h00FF, 8, cap);
    pulse_load();
    n_vec++; if (data_out !== 8'hFF) begin n_err++; $display("FAIL hold_frame_ff: got %h want ff", data_out); end
    wait_clk(1100);
`ifdef EXPANSION_TARGET_WATCHDOG_EN
    n_vec++; if (data_out !== 8'h00) begin n_err++; $display("FAIL watchdog_safe_value: got %h want 00", data_out); end
    n_vec++; if (link_ok !== 1'b0) begin n_err++; $display("FAIL watchdog_link_lost: got %b want 0", link_ok); end
    send_bits(16'h0081, 8, cap);
    pulse_load();
    n_vec++; if (data_out !== 8'h81) begin n_err++; $display("FAIL watchdog_recover_data: got %h want 81", data_out); end
    n_vec++; if (link_ok !== 1'b1) begin n_err++; $display("FAIL watchdog_recover_link: got %b want 1", link_ok); end
`else
    n_vec++; if (data_out !== 8'hFF) begin n_err++; $display("FAIL idle_hold_data: got %h want ff", data_out); end
    n_vec++; if (link_ok !== 1'b1) begin n_err++; $display("FAIL idle_hold_link: got %b want 1", link_ok); end
`endif
  endtask

  task automatic test_mid_reset();
    logic [15:0] cap;
    int fv0;
    data_in = 8'hFF;
    pulse_load();
    send_bits(16'h000F, 4, cap);
    rst = 1'b1;
    wait_clk(3);
    rst = 1'b0;
    wait_clk(1);
    n_vec++; if (data_out !== 8'h00) begin n_err++; $display("FAIL mid_reset_data_out: got %h want 00", data_out); end
    n_vec++; if (link_ok !== 1'b0) begin n_err++; $display("FAIL mid_reset_link_ok: got %b want 0", link_ok); end
    n_vec++; if (shift_sdo !== 1'b0) begin n_err++; $display("FAIL mid_reset_sdo: got %b want 0", shift_sdo); end
    data_in = 8'h00;
    send_bits(16'h005A, 8, cap);
    n_vec++; if (cap[7:0] !== 8'h00) begin n_err++; $display("FAIL mid_reset_tx_cleared: got %h want 00", cap[7:0]); end
    fv0 = fv_cnt;
    pulse_load();
    n_vec++; if (data_out !== 8'h5A) begin n_err++; $display("FAIL post_reset_frame: got %h want 5a", data_out); end
    n_vec++; if (fv_cnt !== fv0 + 1) begin n_err++; $display("FAIL post_reset_valid: got %0d want %0d", fv_cnt, fv0 + 1); end
    n_vec++; if (link_ok !== 1'b1) begin n_err++; $display("FAIL post_reset_link_ok: got %b want 1", link_ok); end
  endtask

  initial begin
    rst        = 1'b1;
    shift_clk  = 1'b0;
    shift_load = 1'b0;
    shift_sdi  = 1'b0;
    data_in    = 8'h00;
    test_reset();
    test_frame();
    test_bad_count();
    test_same_cycle();
    test_link_hold();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
